uart_baudgen: RTL and testbench

UART_BAUDGEN -- requirements
Module: uart_baudgen

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_os_div.sv | 98 +++++++++
 rtl/uart_baudgen.sv | 118 +++++++++++
 tb/tb_uart_baudgen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Used by the baud generator and the other UART blocks.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
  localparam int unsigned BAUD_DEF       = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Truncated oversample divisor for a given clock/baud/oversample.
  function automatic int unsigned calc_div(
    input int unsigned clk_freq,
    input int unsigned baud,
    input int unsigned os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_div.sv
// Oversample divider: period counter, active divisor, tick.
// Fraction accumulator present with UART_BAUDGEN_FRAC_EN.
module uart_os_div #(
  parameter int unsigned      DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef UART_BAUDGEN_FRAC_EN
  input  logic [3:0]       frac_i,
`endif
  output logic             wrap_o,
  output logic             tick_o,
  output logic [DIV_W-1:0] div_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] last;
  logic             wrap;

`ifdef UART_BAUDGEN_FRAC_EN
  logic [3:0] frac_q, frac_d;
  logic [3:0] acc_q, acc_d;
  logic       ext_q, ext_d;
  logic [4:0] sum;

  assign sum  = {1'b0, acc_q} + {1'b0, frac_q};
  assign last = div_q - DIV_W'(1) + DIV_W'(ext_q);
`else
  assign last = div_q - DIV_W'(1);
`endif

  assign wrap   = en_i && (cnt_q == last);
  assign wrap_o = wrap;
  assign tick_o = tick_q;
  assign div_o  = div_q;

  // Next state: restart > wrap > count.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
`ifdef UART_BAUDGEN_FRAC_EN
    frac_d = frac_q;
    acc_d  = acc_q;
    ext_d  = ext_q;
`endif
    if (restart_i) begin
      cnt_d  = '0;
      div_d  = div_i;
`ifdef UART_BAUDGEN_FRAC_EN
      frac_d = frac_i;
      acc_d  = '0;
      ext_d  = 1'b0;
`endif
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      div_d  = div_i;
`ifdef UART_BAUDGEN_FRAC_EN
      frac_d = frac_i;
      acc_d  = sum[3:0];
      ext_d  = sum[4];
`endif
    end else if (en_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      tick_q <= 1'b0;
`ifdef UART_BAUDGEN_FRAC_EN
      frac_q <= '0;
      acc_q  <= '0;
      ext_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
`ifdef UART_BAUDGEN_FRAC_EN
      frac_q <= frac_d;
      acc_q  <= acc_d;
      ext_q  <= ext_d;
`endif
    end
  end

endmodule

// File: rtl/uart_baudgen.sv
// UART baud generator: shadow divisor, baud counter, resync.
// Optional fractional divisor: UART_BAUDGEN_FRAC_EN.
module uart_baudgen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned BAUD_DEFAULT = BAUD_DEF,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W        = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iResync,
  input  logic             iDiv_load,
  input  logic [DIV_W-1:0] iDiv,
`ifdef UART_BAUDGEN_FRAC_EN
  input  logic [3:0]       iFrac,
`endif
  output logic             oOs_tick,
  output logic             oBaud_tick,
  output logic [DIV_W-1:0] oDiv,
  output logic             oCfg_err
);

  localparam logic [DIV_W-1:0] DIV_RST =
    DIV_W'(calc_div(CLK_FREQ, BAUD_DEFAULT, OVERSAMPLE));
  localparam int unsigned BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] B_LAST = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_HALF = BW'(OVERSAMPLE / 2);

  logic [DIV_W-1:0] sh_q, sh_d;
  logic             err_q, err_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             btick_q, btick_d;
  logic             wrap;

`ifdef UART_BAUDGEN_FRAC_EN
  logic [3:0] shf_q, shf_d;
`endif

  // Shadow capture; a zero divisor is rejected and flagged.
  always_comb begin
    sh_d  = sh_q;
    err_d = 1'b0;
`ifdef UART_BAUDGEN_FRAC_EN
    shf_d = shf_q;
`endif
    if (iDiv_load) begin
      if (iDiv == '0) begin
        err_d = 1'b1;
      end else begin
        sh_d  = iDiv;
`ifdef UART_BAUDGEN_FRAC_EN
        shf_d = iFrac;
`endif
      end
    end
  end

  // Baud counter: resync preloads half a bit, wraps emit ticks.
  always_comb begin
    bcnt_d  = bcnt_q;
    btick_d = 1'b0;
    if (iResync) begin
      bcnt_d = B_HALF;
    end else if (wrap) begin
      if (bcnt_q == B_LAST) begin
        bcnt_d  = '0;
        btick_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sh_q    <= DIV_RST;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
      btick_q <= 1'b0;
`ifdef UART_BAUDGEN_FRAC_EN
      shf_q   <= '0;
`endif
    end else begin
      sh_q    <= sh_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
      btick_q <= btick_d;
`ifdef UART_BAUDGEN_FRAC_EN
      shf_q   <= shf_d;
`endif
    end
  end

  uart_os_div #(
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) u_os_div (
    .clk_i     (iClk),
    .rst_i     (iRst),
    .en_i      (iEn),
    .restart_i (iResync),
    .div_i     (sh_d),
`ifdef UART_BAUDGEN_FRAC_EN
    .frac_i    (shf_d),
`endif
    .wrap_o    (wrap),
    .tick_o    (oOs_tick),
    .div_o     (oDiv)
  );

  assign oBaud_tick = btick_q;
  assign oCfg_err   = err_q;

endmodule

// File: tb/tb_uart_baudgen.sv
// Directed bench for uart_baudgen with a tick-interval scoreboard.
module tb_uart_baudgen;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEn;
  logic        iResync;
  logic        iDiv_load;
  logic [15:0] iDiv;
`ifdef UART_BAUDGEN_FRAC_EN
  logic [3:0]  iFrac;
`endif
  logic        oOs_tick;
  logic        oBaud_tick;
  logic [15:0] oDiv;
  logic        oCfg_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  uart_baudgen dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iEn        (iEn),
    .iResync    (iResync),
    .iDiv_load  (iDiv_load),
    .iDiv       (iDiv),
`ifdef UART_BAUDGEN_FRAC_EN
    .iFrac      (iFrac),
`endif
    .oOs_tick   (oOs_tick),
    .oBaud_tick (oBaud_tick),
    .oDiv       (oDiv),
    .oCfg_err   (oCfg_err)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input bit baud, input int budget,
                           output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (baud ? oBaud_tick : oOs_tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic sb_tick(input string tag, input bit baud);
    int e;
    int n;
    e = exp_q.pop_front();
    wait_tick(baud, e + 64, n);
    chk(tag, n, e);
  endtask

  initial begin
    int n;
    bit any;
    iRst      = 1'b1;
    iEn       = 1'b0;
    iResync   = 1'b0;
    iDiv_load = 1'b0;
    iDiv      = '0;
`ifdef UART_BAUDGEN_FRAC_EN
    iFrac     = '0;
`endif
    step();
    step();
    chk("rst_div", oDiv, 325);
    chk("rst_os", oOs_tick, 0);
    chk("rst_baud", oBaud_tick, 0);
    chk("rst_err", oCfg_err, 0);

    iRst = 1'b0;
    iEn  = 1'b1;
    exp_q.push_back(325);
    exp_q.push_back(325);
    exp_q.push_back(4550);
    exp_q.push_back(5200);
    sb_tick("os_first", 0);
    sb_tick("os_period", 0);
    sb_tick("baud_first", 1);
    sb_tick("baud_period", 1);
    chk("baud_with_os", oOs_tick, 1);

    repeat (324) step();
    iResync = 1'b1;
    step();
    iResync = 1'b0;
    chk("resync_os_sup", oOs_tick, 0);
    chk("resync_baud_sup", oBaud_tick, 0);
    exp_q.push_back(2600);
    exp_q.push_back(5200);
    sb_tick("resync_half", 1);
    sb_tick("resync_full", 1);

    iDiv_load = 1'b1;
    iDiv      = 16'd0;
    step();
    iDiv_load = 1'b0;
    chk("div0_err_hi", oCfg_err, 1);
    step();
    chk("div0_err_lo", oCfg_err, 0);
    chk("div0_div", oDiv, 325);
    exp_q.push_back(323);
    exp_q.push_back(325);
    sb_tick("div0_os_a", 0);
    sb_tick("div0_os_b", 0);

    repeat (100) step();
    iDiv_load = 1'b1;
    iDiv      = 16'd10;
    step();
    iDiv_load = 1'b0;
    chk("ld10_div_hold", oDiv, 325);
    exp_q.push_back(224);
    sb_tick("ld10_finish", 0);
    chk("ld10_div_new", oDiv, 10);
    exp_q.push_back(10);
    exp_q.push_back(10);
    sb_tick("ld10_os_a", 0);
    sb_tick("ld10_os_b", 0);

    iDiv_load = 1'b1;
    iDiv      = 16'd325;
    step();
    iDiv_load = 1'b0;
    exp_q.push_back(9);
    exp_q.push_back(325);
    sb_tick("ld325_finish", 0);
    chk("ld325_div", oDiv, 325);
    sb_tick("ld325_os", 0);

    repeat (100) step();
    iEn = 1'b0;
    any = 1'b0;
    repeat (50) begin
      step();
      if (oOs_tick || oBaud_tick) any = 1'b1;
    end
    chk("pause_ticks", any, 0);
    iEn = 1'b1;
    exp_q.push_back(225);
    sb_tick("pause_resume", 0);

    repeat (50) step();
    iDiv_load = 1'b1;
    iDiv      = 16'd10;
    step();
    iDiv_load = 1'b0;
    repeat (200) step();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    chk("rst_mid_div", oDiv, 325);
    chk("rst_mid_os", oOs_tick, 0);
    exp_q.push_back(325);
    exp_q.push_back(325);
    sb_tick("rst_mid_os_a", 0);
    sb_tick("rst_mid_os_b", 0);

    iResync   = 1'b1;
    iDiv_load = 1'b1;
    iDiv      = 16'd1;
    step();
    iResync   = 1'b0;
    iDiv_load = 1'b0;
    chk("rsld_div", oDiv, 1);
    chk("rsld_os_sup", oOs_tick, 0);
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(6);
    exp_q.push_back(16);
    sb_tick("div1_os_a", 0);
    sb_tick("div1_os_b", 0);
    sb_tick("div1_baud_half", 1);
    sb_tick("div1_baud_full", 1);

`ifdef UART_BAUDGEN_FRAC_EN
    iDiv_load = 1'b1;
    iDiv      = 16'd325;
    iFrac     = 4'd8;
    step();
    iDiv_load = 1'b0;
    wait_tick(1'b1, 6000, n);
    exp_q.push_back(5208);
    sb_tick("frac_baud", 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
